edge_multi_dataflow: RTL and testbench

//   Reconfigurable streaming edge detector: one datapath, kernel selected by ID
//   (1 = Roberts 2x2, 2 = Sobel 3x3). Accepts a frame-width token, then a raster

---
 rtl/edge_multi_dataflow.sv | 198 +++++++++++++++++++
 tb/tb_edge_multi_dataflow.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/edge_multi_dataflow.sv
// Streaming edge detector: Roberts 2x2 or Sobel 3x3 gradient magnitude over a W x W
// raster frame, with wr/full handshakes on the size, pixel and output ports.
module edge_multi_dataflow #(
    parameter int unsigned MAX_W = 63
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] ID,
    input  logic [5:0] in_size_data,
    input  logic       in_size_wr,
    output logic       in_size_full,
    input  logic [7:0] in_pel_data,
    input  logic       in_pel_wr,
    output logic       in_pel_full,
    output logic [7:0] out_pel_data,
    output logic       out_pel_wr,
    input  logic       out_pel_full
);

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    localparam logic [7:0] IdRoberts = 8'd1;
    localparam logic [7:0] IdSobel   = 8'd2;

    state_e     state_q, state_d;
    logic [5:0] w_q, w_d;
    logic [5:0] frame_w_q, frame_w_d;
    logic [7:0] frame_id_q, frame_id_d;
    logic [5:0] row_q, row_d;
    logic [5:0] col_q, col_d;
    logic       out_wr_q, out_wr_d;
    logic [7:0] out_data_q, out_data_d;

    // Window columns: c1 is column c-1, c2 is column c-2; t/m/b are rows r-2, r-1, r.
    logic [7:0] c1_t_q, c1_m_q, c1_b_q, c1_t_d, c1_m_d, c1_b_d;
    logic [7:0] c2_t_q, c2_m_q, c2_b_q, c2_t_d, c2_m_d, c2_b_d;

    // lb0 holds row r-1, lb1 holds row r-2.
    logic [7:0] lb0 [MAX_W];
    logic [7:0] lb1 [MAX_W];

    logic       size_acc;
    logic       pel_acc;
    logic       first_pel;
    logic [5:0] cur_w;
    logic [7:0] cur_id;
    logic       last_col;
    logic       last_row;
    logic [7:0] up1;
    logic [7:0] up2;
    logic       emit_sob;
    logic       emit_rob;

    logic [11:0] right_sum, left_sum, bottom_sum, top_sum;
    logic [11:0] gx, gy, sob_mag;
    logic [11:0] rd1, rd2, rob_mag;

    function automatic logic [11:0] ext(input logic [7:0] v);
        return {4'd0, v};
    endfunction

    // Operand is a 12-bit two's-complement value.
    function automatic logic [11:0] abs12(input logic [11:0] v);
        return v[11] ? (~v + 12'd1) : v;
    endfunction

    function automatic logic [7:0] sat8(input logic [11:0] v);
        return (v > 12'd255) ? 8'hFF : v[7:0];
    endfunction

    assign in_size_full = (state_q == StRun) && ((row_q != 6'd0) || (col_q != 6'd0));
    assign in_pel_full  = (state_q == StIdle) || (out_wr_q && out_pel_full);
    assign out_pel_wr   = out_wr_q;
    assign out_pel_data = out_data_q;

    assign size_acc  = in_size_wr && !in_size_full;
    assign pel_acc   = in_pel_wr && !in_pel_full;
    assign first_pel = (row_q == 6'd0) && (col_q == 6'd0);
    assign cur_w     = first_pel ? w_q : frame_w_q;
    assign cur_id    = first_pel ? ID : frame_id_q;
    assign last_col  = (col_q == cur_w - 6'd1);
    assign last_row  = (row_q == cur_w - 6'd1);
    assign up1       = lb0[col_q];
    assign up2       = lb1[col_q];

    always_comb begin
        right_sum  = ext(up2) + (ext(up1) << 1) + ext(in_pel_data);
        left_sum   = ext(c2_t_q) + (ext(c2_m_q) << 1) + ext(c2_b_q);
        bottom_sum = ext(c2_b_q) + (ext(c1_b_q) << 1) + ext(in_pel_data);
        top_sum    = ext(c2_t_q) + (ext(c1_t_q) << 1) + ext(up2);
        gx         = right_sum - left_sum;
        gy         = bottom_sum - top_sum;
        sob_mag    = abs12(gx) + abs12(gy);
        // Roberts: a = c1_m, b = up1, d = c1_b, e = current pixel.
        rd1        = ext(c1_m_q) - ext(in_pel_data);
        rd2        = ext(up1) - ext(c1_b_q);
        rob_mag    = abs12(rd1) + abs12(rd2);
    end

    assign emit_sob = (cur_id == IdSobel) && (row_q >= 6'd2) && (col_q >= 6'd2);
    assign emit_rob = (cur_id == IdRoberts) && (row_q >= 6'd1) && (col_q >= 6'd1);

    always_comb begin
        state_d    = state_q;
        w_d        = w_q;
        frame_w_d  = frame_w_q;
        frame_id_d = frame_id_q;
        row_d      = row_q;
        col_d      = col_q;
        out_wr_d   = out_wr_q;
        out_data_d = out_data_q;
        c1_t_d     = c1_t_q;
        c1_m_d     = c1_m_q;
        c1_b_d     = c1_b_q;
        c2_t_d     = c2_t_q;
        c2_m_d     = c2_m_q;
        c2_b_d     = c2_b_q;

        // A zero width is never accepted as a frame size.
        if (size_acc && (in_size_data != 6'd0)) begin
            w_d     = in_size_data;
            state_d = StRun;
        end

        if (out_wr_q && !out_pel_full) begin
            out_wr_d = 1'b0;
        end

        if (pel_acc) begin
            if (first_pel) begin
                frame_w_d  = w_q;
                frame_id_d = ID;
            end
            if (last_col) begin
                col_d = 6'd0;
                row_d = last_row ? 6'd0 : row_q + 6'd1;
            end else begin
                col_d = col_q + 6'd1;
            end
            c2_t_d = c1_t_q;
            c2_m_d = c1_m_q;
            c2_b_d = c1_b_q;
            c1_t_d = up2;
            c1_m_d = up1;
            c1_b_d = in_pel_data;
            if (emit_sob) begin
                out_wr_d   = 1'b1;
                out_data_d = sat8(sob_mag);
            end else if (emit_rob) begin
                out_wr_d   = 1'b1;
                out_data_d = sat8(rob_mag);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q    <= StIdle;
            w_q        <= 6'd0;
            frame_w_q  <= 6'd0;
            frame_id_q <= 8'd0;
            row_q      <= 6'd0;
            col_q      <= 6'd0;
            out_wr_q   <= 1'b0;
            out_data_q <= 8'd0;
            c1_t_q     <= 8'd0;
            c1_m_q     <= 8'd0;
            c1_b_q     <= 8'd0;
            c2_t_q     <= 8'd0;
            c2_m_q     <= 8'd0;
            c2_b_q     <= 8'd0;
        end else begin
            state_q    <= state_d;
            w_q        <= w_d;
            frame_w_q  <= frame_w_d;
            frame_id_q <= frame_id_d;
            row_q      <= row_d;
            col_q      <= col_d;
            out_wr_q   <= out_wr_d;
            out_data_q <= out_data_d;
            c1_t_q     <= c1_t_d;
            c1_m_q     <= c1_m_d;
            c1_b_q     <= c1_b_d;
            c2_t_q     <= c2_t_d;
            c2_m_q     <= c2_m_d;
            c2_b_q     <= c2_b_d;
        end
    end

    // Line buffer contents are don't-care across reset, so no reset here.
    always_ff @(posedge clock) begin
        if (pel_acc) begin
            lb1[col_q] <= lb0[col_q];
            lb0[col_q] <= in_pel_data;
        end
    end

endmodule

// File: tb/tb_edge_multi_dataflow.sv
// Scoreboard bench for edge_multi_dataflow: directed frames push expected magnitudes,
// an independent monitor pops and compares each delivered output.
module tb_edge_multi_dataflow;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] ID = 8'd0;
    logic [5:0] in_size_data = 6'd0;
    logic       in_size_wr = 1'b0;
    logic       in_size_full;
    logic [7:0] in_pel_data = 8'd0;
    logic       in_pel_wr = 1'b0;
    logic       in_pel_full;
    logic [7:0] out_pel_data;
    logic       out_pel_wr;
    logic       out_pel_full = 1'b0;

    int         errors = 0;
    int         checks = 0;
    int         out_cnt = 0;
    bit         lat_chk = 1'b0;
    logic [7:0] exp_q[$];

    edge_multi_dataflow #(.MAX_W(63)) dut (
        .clock       (clock),
        .reset       (reset),
        .ID          (ID),
        .in_size_data(in_size_data),
        .in_size_wr  (in_size_wr),
        .in_size_full(in_size_full),
        .in_pel_data (in_pel_data),
        .in_pel_wr   (in_pel_wr),
        .in_pel_full (in_pel_full),
        .out_pel_data(out_pel_data),
        .out_pel_wr  (out_pel_wr),
        .out_pel_full(out_pel_full)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: every cycle where an output is offered and the sink is ready is a transfer.
    always @(negedge clock) begin
        if (reset && out_pel_wr && !out_pel_full) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: got %0d expected none", out_pel_data);
            end else begin
                check("out_pel_data", int'(out_pel_data), int'(exp_q.pop_front()));
            end
            out_cnt++;
        end
    end

    task automatic do_reset();
        reset        = 1'b0;
        in_pel_wr    = 1'b0;
        in_size_wr   = 1'b0;
        out_pel_full = 1'b0;
        repeat (2) @(negedge clock);
        check("rst_out_pel_wr", int'(out_pel_wr), 0);
        check("rst_out_pel_data", int'(out_pel_data), 0);
        check("rst_in_pel_full", int'(in_pel_full), 1);
        check("rst_in_size_full", int'(in_size_full), 0);
        exp_q.delete();
        reset = 1'b1;
    endtask

    task automatic write_size(input logic [5:0] w);
        in_size_data = w;
        in_size_wr   = 1'b1;
        @(posedge clock);
        @(negedge clock);
        in_size_wr = 1'b0;
    endtask

    // Called at a negedge; returns at the negedge after the pixel is accepted.
    task automatic send_pel(input logic [7:0] p, input bit has_out, input logic [7:0] val);
        int guard;
        guard       = 0;
        in_pel_data = p;
        in_pel_wr   = 1'b1;
        while (in_pel_full && guard < 200) begin
            @(negedge clock);
            guard++;
        end
        if (guard >= 200) check("pel_stall_timeout", guard, 0);
        if (has_out) exp_q.push_back(val);
        @(posedge clock);
        @(negedge clock);
        in_pel_wr = 1'b0;
        if (lat_chk) check("out_latency", int'(out_pel_wr), int'(has_out));
    endtask

    task automatic drain_check(input string name, input int base, input int n_exp);
        repeat (8) @(negedge clock);
        check({name, "_queue_empty"}, exp_q.size(), 0);
        check({name, "_out_count"}, out_cnt - base, n_exp);
    endtask

    task automatic sobel_frame6(input int npix);
        for (int i = 0; i < npix; i++) begin
            int r, c;
            r = i / 6;
            c = i % 6;
            send_pel(8'(i + 1), (i < 36) && (r >= 2) && (c >= 2), 8'd56);
        end
    endtask

    initial begin
        int base;
        logic [7:0] held;

        // 1: reset
        do_reset();

        // 2: Sobel 6x6 ramp plus the first row of a second frame
        ID      = 8'd2;
        write_size(6'd6);
        lat_chk = 1'b1;
        base    = out_cnt;
        sobel_frame6(42);
        drain_check("sobel", base, 16);
        check("sobel_size_full_midframe", int'(in_size_full), 1);

        // 3: Roberts 5x5 ramp
        do_reset();
        ID   = 8'd1;
        write_size(6'd5);
        base = out_cnt;
        for (int i = 0; i < 25; i++) begin
            send_pel(8'(i + 1), (i / 5 >= 1) && (i % 5 >= 1), 8'd10);
        end
        drain_check("roberts", base, 16);
        check("roberts_size_free_at_boundary", int'(in_size_full), 0);

        // 4: Sobel saturation, step edge 0,0,255
        do_reset();
        ID   = 8'd2;
        write_size(6'd3);
        base = out_cnt;
        for (int i = 0; i < 9; i++) begin
            send_pel((i % 3 == 2) ? 8'd255 : 8'd0, i == 8, 8'd255);
        end
        drain_check("saturation", base, 1);

        // 5: Sobel with sink backpressure at the third output
        do_reset();
        ID      = 8'd2;
        write_size(6'd6);
        lat_chk = 1'b0;
        base    = out_cnt;
        fork
            sobel_frame6(36);
            begin
                int g;
                g = 0;
                while (!(out_pel_wr && (out_cnt - base) == 2) && g < 500) begin
                    @(posedge clock);
                    #1;
                    g++;
                end
                if (g >= 500) check("bp_third_output_timeout", g, 0);
                held         = out_pel_data;
                out_pel_full = 1'b1;
                repeat (5) begin
                    @(posedge clock);
                    #1;
                    check("bp_hold_wr", int'(out_pel_wr), 1);
                    check("bp_hold_data", int'(out_pel_data), int'(held));
                    check("bp_in_pel_full", int'(in_pel_full), 1);
                end
                out_pel_full = 1'b0;
            end
        join
        drain_check("backpressure", base, 16);

        // 6: size port mid-frame is blocked; width 4 must persist
        do_reset();
        ID      = 8'd1;
        write_size(6'd4);
        lat_chk = 1'b1;
        base    = out_cnt;
        send_pel(8'd1, 1'b0, 8'd0);
        check("size_full_midframe", int'(in_size_full), 1);
        write_size(6'd2);
        for (int i = 1; i < 16; i++) begin
            send_pel(8'(i + 1), (i / 4 >= 1) && (i % 4 >= 1), 8'd8);
        end
        drain_check("size_blocked", base, 9);
        check("size_free_after_frame", int'(in_size_full), 0);

        // 6b: width 0 from IDLE is ignored
        do_reset();
        write_size(6'd0);
        check("zero_size_pel_full", int'(in_pel_full), 1);
        check("zero_size_size_full", int'(in_size_full), 0);
        in_pel_data = 8'd9;
        in_pel_wr   = 1'b1;
        repeat (2) @(negedge clock);
        in_pel_wr = 1'b0;
        check("zero_size_no_output", int'(out_pel_wr), 0);
        check("zero_size_still_idle", int'(in_pel_full), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

endmodule
